regfile_wb_arbiter: RTL and testbench

//  Write-port controller for the 32x32 register file. Shares the file's single

---
 rtl/regfile_wb_arbiter.sv | 119 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: round-robin over NREQ writeback requesters
// plus a post-reset zero-clear sweep. Optional macro: REGWB_ZERO_GUARD_EN.
module regfile_wb_arbiter #(
  parameter int NREQ           = 2,
  parameter int AW             = 5,
  parameter int DW             = 32,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 wr_en,
  output logic                 wr_dst,
  output logic [AW-1:0]        wr_addr,
  output logic [DW-1:0]        wr_data,
  output logic                 clear_done
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [AW:0] CNT_LAST = {1'b0, {AW{1'b1}}};

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t          state, state_nxt;
  logic [AW:0]     cnt;
  logic [PW-1:0]   ptr, ptr_nxt, win_idx, idx;
  logic [PW:0]     sum;
  logic            found, xfer, wr_en_nxt;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == S_CLEAR && cnt == CNT_LAST) state_nxt = S_RUN;
  end

  // Round-robin search starting at ptr; the modulo is done by a single
  // conditional subtract so non-power-of-two NREQ works.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    sum     = '0;
    idx     = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
      idx = sum[PW-1:0];
      if (!found && req_valid[idx]) begin
        found   = 1'b1;
        win_idx = idx;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    xfer      = 1'b0;
    if (state == S_RUN && found) begin
      req_ready[win_idx] = 1'b1;
      xfer               = 1'b1;
    end
  end

  always_comb begin
    win_addr = '0;
    win_data = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (win_idx == PW'(k)) begin
        win_addr = req_addr[k*AW +: AW];
        win_data = req_data[k*DW +: DW];
      end
    end
    ptr_nxt = (win_idx == PW'(NREQ-1)) ? '0 : win_idx + 1'b1;
  end

`ifdef REGWB_ZERO_GUARD_EN
  assign wr_en_nxt = (win_addr != '0);
`else
  assign wr_en_nxt = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      clear_done <= 1'b0;
      cnt        <= '0;
      ptr        <= '0;
    end else if (state == S_CLEAR) begin
      wr_en   <= 1'b1;
      wr_addr <= cnt[AW-1:0];
      wr_data <= '0;
      cnt     <= cnt + 1'b1;
      if (cnt == CNT_LAST) clear_done <= 1'b1;
    end else begin
      clear_done <= 1'b1;
      if (xfer) begin
        wr_en   <= wr_en_nxt;
        wr_addr <= win_addr;
        wr_data <= win_data;
        ptr     <= ptr_nxt;
      end else begin
        wr_en <= 1'b0;
      end
    end
  end

  assign wr_dst = wr_en;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter: clear sweep, handshake, round-robin,
// address-0 handling, mid-sweep reset and the no-clear configuration.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rst_n2 = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [9:0]  req_addr = '0;
  logic [63:0] req_data = '0;

  logic [1:0]  req_ready, req_ready2;
  logic        wr_en, wr_dst, clear_done, wr_en2, wr_dst2, clear_done2;
  logic [4:0]  wr_addr, wr_addr2;
  logic [31:0] wr_data, wr_data2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.NREQ(2), .AW(5), .DW(32), .CLEAR_ON_RESET(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .wr_en(wr_en), .wr_dst(wr_dst),
    .wr_addr(wr_addr), .wr_data(wr_data), .clear_done(clear_done)
  );

  regfile_wb_arbiter #(.NREQ(2), .AW(5), .DW(32), .CLEAR_ON_RESET(0)) u_dut_nc (
    .clk(clk), .rst_n(rst_n2), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready2), .wr_en(wr_en2), .wr_dst(wr_dst2),
    .wr_addr(wr_addr2), .wr_data(wr_data2), .clear_done(clear_done2)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [1:0] v, input logic [4:0] a0, input logic [31:0] d0,
                         input logic [4:0] a1, input logic [31:0] d1);
    req_valid = v;
    req_addr  = {a1, a0};
    req_data  = {d1, d0};
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    set_req(2'b11, 5'd1, 32'h1, 5'd2, 32'h2);
    tick; tick;
    n_cmp++; if ({wr_en, wr_dst} !== 2'b00) begin n_bad++; $display("FAIL reset_wr_en: got %b exp 00", {wr_en, wr_dst}); end
    n_cmp++; if (wr_addr !== 5'd0) begin n_bad++; $display("FAIL reset_wr_addr: got %0d exp 0", wr_addr); end
    n_cmp++; if (wr_data !== 32'h0) begin n_bad++; $display("FAIL reset_wr_data: got %h exp 0", wr_data); end
    n_cmp++; if (clear_done !== 1'b0) begin n_bad++; $display("FAIL reset_clear_done: got %b exp 0", clear_done); end
    n_cmp++; if (req_ready !== 2'b00) begin n_bad++; $display("FAIL reset_req_ready: got %b exp 00", req_ready); end
  endtask

  task automatic test_clear;
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      #1;
      n_cmp++; if (req_ready !== 2'b00) begin n_bad++; $display("FAIL clear_ready[%0d]: got %b exp 00", i, req_ready); end
      tick;
      n_cmp++; if (wr_en !== 1'b1 || wr_dst !== 1'b1) begin n_bad++; $display("FAIL clear_wr_en[%0d]: got %b%b exp 11", i, wr_en, wr_dst); end
      n_cmp++; if (wr_addr !== 5'(i)) begin n_bad++; $display("FAIL clear_addr[%0d]: got %0d exp %0d", i, wr_addr, i); end
      n_cmp++; if (wr_data !== 32'h0) begin n_bad++; $display("FAIL clear_data[%0d]: got %h exp 0", i, wr_data); end
      n_cmp++; if (clear_done !== (i == 31)) begin n_bad++; $display("FAIL clear_done[%0d]: got %b exp %b", i, clear_done, (i == 31)); end
    end
    set_req(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    tick;
    n_cmp++; if (wr_en !== 1'b0) begin n_bad++; $display("FAIL post_clear_idle: got %b exp 0", wr_en); end
    n_cmp++; if (clear_done !== 1'b1) begin n_bad++; $display("FAIL post_clear_done: got %b exp 1", clear_done); end
  endtask

  task automatic test_single;
    set_req(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0);
    #1;
    n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL single_ready: got %b exp 01", req_ready); end
    tick;
    set_req(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    n_cmp++; if (wr_en !== 1'b1 || wr_dst !== 1'b1) begin n_bad++; $display("FAIL single_wr_en: got %b%b exp 11", wr_en, wr_dst); end
    n_cmp++; if (wr_addr !== 5'd5) begin n_bad++; $display("FAIL single_addr: got %0d exp 5", wr_addr); end
    n_cmp++; if (wr_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL single_data: got %h exp deadbeef", wr_data); end
    tick;
    n_cmp++; if (wr_en !== 1'b0) begin n_bad++; $display("FAIL single_idle: got %b exp 0", wr_en); end
    n_cmp++; if (wr_addr !== 5'd5 || wr_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL single_hold: got %0d/%h exp 5/deadbeef", wr_addr, wr_data); end
  endtask

  // Pointer is 1 after test_single, so req 1 wins here and the pointer returns to 0.
  task automatic test_zero_addr;
    set_req(2'b10, 5'd0, 32'h0, 5'd0, 32'h1234);
    #1;
    n_cmp++; if (req_ready !== 2'b10) begin n_bad++; $display("FAIL zero_ready: got %b exp 10", req_ready); end
    tick;
    set_req(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
`ifdef REGWB_ZERO_GUARD_EN
    n_cmp++; if (wr_en !== 1'b0 || wr_dst !== 1'b0) begin n_bad++; $display("FAIL zero_guard_wr_en: got %b%b exp 00", wr_en, wr_dst); end
`else
    n_cmp++; if (wr_en !== 1'b1 || wr_dst !== 1'b1) begin n_bad++; $display("FAIL zero_wr_en: got %b%b exp 11", wr_en, wr_dst); end
    n_cmp++; if (wr_addr !== 5'd0 || wr_data !== 32'h1234) begin n_bad++; $display("FAIL zero_payload: got %0d/%h exp 0/1234", wr_addr, wr_data); end
`endif
  endtask

  task automatic test_round_robin;
    logic [1:0]  exp_ready [6] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
    logic [31:0] exp_data  [6] = '{32'hA0, 32'hB0, 32'hA1, 32'hB1, 32'hA2, 32'hB2};
    logic [4:0]  exp_addr  [6] = '{5'd7, 5'd9, 5'd7, 5'd9, 5'd7, 5'd9};
    logic [31:0] d0, d1;
    d0 = 32'hA0;
    d1 = 32'hB0;
    for (int c = 0; c < 6; c++) begin
      set_req(2'b11, 5'd7, d0, 5'd9, d1);
      #1;
      n_cmp++; if (req_ready !== exp_ready[c]) begin n_bad++; $display("FAIL rr_ready[%0d]: got %b exp %b", c, req_ready, exp_ready[c]); end
      tick;
      n_cmp++; if (wr_en !== 1'b1) begin n_bad++; $display("FAIL rr_wr_en[%0d]: got %b exp 1", c, wr_en); end
      n_cmp++; if (wr_data !== exp_data[c] || wr_addr !== exp_addr[c]) begin n_bad++; $display("FAIL rr_payload[%0d]: got %0d/%h exp %0d/%h", c, wr_addr, wr_data, exp_addr[c], exp_data[c]); end
      if (exp_ready[c][0]) d0 = d0 + 1;
      else                 d1 = d1 + 1;
    end
    set_req(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    tick;
    n_cmp++; if (wr_en !== 1'b0) begin n_bad++; $display("FAIL rr_idle: got %b exp 0", wr_en); end
  endtask

  task automatic test_reset_mid_clear;
    tick;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) tick;
    n_cmp++; if (wr_addr !== 5'd9) begin n_bad++; $display("FAIL mid_pre_addr: got %0d exp 9", wr_addr); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (wr_en !== 1'b0 || wr_addr !== 5'd0 || wr_data !== 32'h0 || clear_done !== 1'b0) begin
      n_bad++; $display("FAIL mid_async: got en=%b addr=%0d data=%h done=%b exp all 0", wr_en, wr_addr, wr_data, clear_done);
    end
    tick;
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      tick;
      n_cmp++; if (wr_en !== 1'b1 || wr_addr !== 5'(i)) begin n_bad++; $display("FAIL mid_sweep[%0d]: got en=%b addr=%0d exp 1/%0d", i, wr_en, wr_addr, i); end
      n_cmp++; if (clear_done !== (i == 31)) begin n_bad++; $display("FAIL mid_done[%0d]: got %b exp %b", i, clear_done, (i == 31)); end
    end
  endtask

  task automatic test_no_clear;
    n_cmp++; if (clear_done2 !== 1'b0 || wr_en2 !== 1'b0) begin n_bad++; $display("FAIL nc_reset: got done=%b en=%b exp 0/0", clear_done2, wr_en2); end
    rst_n2 = 1'b1;
    set_req(2'b01, 5'd3, 32'h55, 5'd0, 32'h0);
    #1;
    n_cmp++; if (req_ready2 !== 2'b01) begin n_bad++; $display("FAIL nc_ready: got %b exp 01", req_ready2); end
    tick;
    set_req(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    n_cmp++; if (clear_done2 !== 1'b1) begin n_bad++; $display("FAIL nc_done: got %b exp 1", clear_done2); end
    n_cmp++; if (wr_en2 !== 1'b1 || wr_dst2 !== 1'b1 || wr_addr2 !== 5'd3 || wr_data2 !== 32'h55) begin
      n_bad++; $display("FAIL nc_write: got en=%b dst=%b addr=%0d data=%h exp 1/1/3/55", wr_en2, wr_dst2, wr_addr2, wr_data2);
    end
  endtask

  initial begin
    #1;
    test_reset;
    test_clear;
    test_single;
    test_zero_addr;
    test_round_robin;
    test_reset_mid_clear;
    test_no_clear;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
